window_row_feeder: RTL and testbench
====================================

# window_row_feeder

Streaming front end for the disparity engine (`compute_max_disp`). It takes raster-order pixels one per clock with a valid/ready handshake and keeps a sliding stack of the WIN most recent complete image rows. It presents that stack as the flattened `input_array` bus the engine consumes, holds it until the engine pulses done, then slides the stack down by one row.

## Interface
- `WIN`, 15, window height in rows.
- `DATA_SIZE`, 8, bits per pixel.
- `IMG_W`, 64, pixels per image row.
- `CNT_W`, 16, width of `win_count`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `pix_in`  in  DATA_SIZE  incoming pixel, raster order.
- `pix_valid`  in  1  `pix_in`/`pix_sof` are valid.
- `pix_sof`  in  1  the current pixel is row 0, column 0 of a new frame.
- `pix_ready`  out  1  the feeder accepts the pixel this cycle (transfer = `pix_valid & pix_ready`).
- `input_array`  out  DATA_SIZE*IMG_W*WIN  window bus. Element i sits at `[i*DATA_SIZE +: DATA_SIZE]`, with i = r*IMG_W + c. Row r=0 is the oldest row, r=WIN-1 the newest.
- `win_valid`  out  1  `input_array` holds a complete WIN-row window.
- `win_done`  in  1  engine finished the current window; single-cycle pulse.
- `win_count`  out  CNT_W  windows presented since the last sof or reset, wrapping.

## Operation
- Incoming pixels collect into a one-row staging line `new_row`, indexed by `col_cnt` (0..IMG_W-1).
- The accepted pixel at `col_cnt`=IMG_W-1 completes the row.
- On row completion the stack shifts: row r takes row r+1, and row WIN-1 takes `new_row` including the completing pixel. `row_cnt` increments, saturating at WIN.
- States:
  - FILL: `pix_ready`=1, `win_valid`=0. A row completion that brings `row_cnt` to WIN goes to PRESENT.
  - PRESENT: `win_valid`=1; `input_array` is stable. `pix_ready` is 0, except under prefetch (see Configuration).
  - On `win_done` in PRESENT: if a staged row is pending (prefetch only), shift and stay in PRESENT; otherwise go to FILL with `row_cnt`=WIN-1, so one new row re-presents.
- `win_count` increments on every FILL→PRESENT transition and on every PRESENT→PRESENT shift.
- Accepted `pix_sof`:
  - clears `row_cnt` and `win_count`, and discards any pending row;
  - is written as column 0 (`col_cnt` becomes 1);
  - forces FILL, so `win_valid` is 0 from the next cycle.
- `win_done` while `win_valid`=0 is ignored.
- Pixels are unsigned DATA_SIZE-bit values, stored unmodified. No arithmetic is done on them.
- A missing sof is not an error: columns wrap at IMG_W and rows keep sliding.

## Timing
- Reset values:
  - `pix_ready`=0 while `rst` is high, 1 from the first edge after release.
  - `win_valid`=0, `input_array`=0, `win_count`=0.
  - State FILL, `col_cnt`=`row_cnt`=0.
- Latency: when the completing pixel of the WIN-th row is accepted at edge E, `win_valid` is 1 and `input_array` is updated in the cycle after E.
- `win_done` sampled at edge E:
  - with no pending row, `win_valid` is 0 after E;
  - with a pending row, `win_valid` stays 1 and `input_array` shows the shifted window after E.
- `win_done` and an accepted completing pixel at the same edge (prefetch): the completing pixel finishes `new_row` and the shift uses it at that edge.
- `rst` mid-frame: all state is cleared immediately; the frame restarts from the next sof or from column 0.

## Configuration
- `WRF_PREFETCH_EN` defined:
  - in PRESENT, `pix_ready`=1 until `new_row` is complete;
  - a completed row sets `row_pending`, drops `pix_ready`, and waits for `win_done`;
  - back-to-back windows incur zero bubble cycles.
- Undefined:
  - `pix_ready`=0 throughout PRESENT; `row_pending` does not exist;
  - each new window costs IMG_W accept cycles after `win_done`.

## Structure
- Shared package `stereo_pkg`: default `WIN`/`DATA_SIZE`/`IMG_W`, the state enum (FILL, PRESENT), and the flat-index helper r*IMG_W+c.
- One sub-module, `row_collector`, holds `new_row`, `col_cnt`, the completion strobe and `row_pending`.
- The top level owns the row stack, the FSM and `win_count`.

## Test plan
- **Fill from reset:** WIN=3, IMG_W=4, pixel value = row*16+col, pix_valid held high. Required: `win_valid` rises the cycle after the 12th accepted pixel; element 0 = 0x00, element 11 = 0x23; `win_count`=1.
- **Slide without prefetch:** `win_done` pulse, then 4 pixels 0x30..0x33. Required: `win_valid` 0 for exactly 5 cycles; new window row 0 = 0x10..0x13, row 2 = 0x30..0x33; `win_count`=2.
- **Slide with prefetch** (`WRF_PREFETCH_EN`): row 3 is streamed during PRESENT. Required: `pix_ready` drops after the 4th pixel; `win_done` shifts the window with `win_valid` held at 1.
- **Mid-window sof:** `pix_sof` accepted during fill of row 1. Required: `row_cnt`=0, `col_cnt`=1, `win_count`=0; the first window appears only after 3 further full rows.
- **Async reset in PRESENT:** `rst` pulsed between edges. Required: `win_valid`, `input_array` and `pix_ready` go to 0 before the next edge.
- **Spurious done:** `win_done` pulsed during FILL. Required: no state change and no `win_count` change.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo front end: default geometry, the feeder
// state type and the flat window index helper.
package stereo_pkg;

  localparam int unsigned WinDef      = 15;
  localparam int unsigned DataSizeDef = 8;
  localparam int unsigned ImgWDef     = 64;

  typedef enum logic [0:0] {
    StFill,
    StPresent
  } feeder_state_e;

  // Element index of row r, column c inside the flattened window bus.
  function automatic int unsigned flat_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned img_w);
    return r * img_w + c;
  endfunction

endpackage

// File: rtl/row_collector.sv
// Staging line for one image row: collects accepted pixels by column, flags
// the completing pixel and, when WRF_PREFETCH_EN is defined, remembers a
// completed row that is waiting for the engine to release the window.
module row_collector
  import stereo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DataSizeDef,
  parameter int unsigned IMG_W     = ImgWDef
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_SIZE-1:0]       pix_in,
  input  logic                       pix_sof,
  input  logic                       accept,
  input  logic                       hold_row,    // a completing row must wait for win_done
  input  logic                       consume,     // the pending row is shifted this edge
  output logic [DATA_SIZE*IMG_W-1:0] row_data,
  output logic                       row_done,
  output logic                       row_pending
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [DATA_SIZE*IMG_W-1:0] new_row_q;
  logic [ColW-1:0]            col_cnt_q, col_cnt_d;
  int unsigned                col_idx;

  // sof is always column 0, so it never completes a row
  assign row_done = accept && !pix_sof && (col_cnt_q == ColW'(IMG_W - 1));

  // Staged row with the pixel accepted this cycle already merged in, so a
  // shift at the completing edge sees the full row.
  always_comb begin
    row_data = new_row_q;
    col_idx  = pix_sof ? 0 : 32'(col_cnt_q);
    if (accept) begin
      row_data[col_idx*DATA_SIZE +: DATA_SIZE] = pix_in;
    end
  end

  // Column counter: sof restarts at column 1, otherwise wrap at IMG_W.
  always_comb begin
    col_cnt_d = col_cnt_q;
    if (accept) begin
      if (pix_sof) begin
        col_cnt_d = ColW'(1);
      end else if (col_cnt_q == ColW'(IMG_W - 1)) begin
        col_cnt_d = '0;
      end else begin
        col_cnt_d = col_cnt_q + ColW'(1);
      end
    end
  end

  // Staging line and column registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_row_q <= '0;
      col_cnt_q <= '0;
    end else begin
      new_row_q <= row_data;
      col_cnt_q <= col_cnt_d;
    end
  end

`ifdef WRF_PREFETCH_EN
  logic row_pending_q;

  // A row finished while the window is held waits here until win_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_pending_q <= 1'b0;
    end else if (accept && pix_sof) begin
      row_pending_q <= 1'b0;
    end else if (consume) begin
      row_pending_q <= 1'b0;
    end else if (row_done && hold_row) begin
      row_pending_q <= 1'b1;
    end
  end

  assign row_pending = row_pending_q;
`else
  logic unused_ok;
  assign unused_ok   = ^{hold_row, consume};
  assign row_pending = 1'b0;
`endif

endmodule

// File: rtl/window_row_feeder.sv
// Streaming window feeder: keeps the WIN most recent complete rows as a
// flattened bus for the disparity engine and slides by one row per win_done.
// Optional feature: define WRF_PREFETCH_EN to stream the next row while a
// window is being presented.
module window_row_feeder
  import stereo_pkg::*;
#(
  parameter int unsigned WIN       = WinDef,
  parameter int unsigned DATA_SIZE = DataSizeDef,
  parameter int unsigned IMG_W     = ImgWDef,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_SIZE-1:0]           pix_in,
  input  logic                           pix_valid,
  input  logic                           pix_sof,
  output logic                           pix_ready,
  output logic [DATA_SIZE*IMG_W*WIN-1:0] input_array,
  output logic                           win_valid,
  input  logic                           win_done,
  output logic [CNT_W-1:0]               win_count
);

  localparam int unsigned RowW = DATA_SIZE * IMG_W;
  localparam int unsigned RcW  = $clog2(WIN + 1);

  feeder_state_e    state_q, state_d;
  logic [RcW-1:0]   row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] win_count_q, win_count_d;
  logic [RowW-1:0]  stack_q [WIN];
  logic             rdy_q;

  logic             accept, sof_acc, shift, hold_row, consume;
  logic             row_done, row_pending;
  logic [RowW-1:0]  row_data;

  assign accept   = pix_valid && pix_ready;
  assign sof_acc  = accept && pix_sof;
  assign hold_row = (state_q == StPresent) && !win_done;
  assign consume  = (state_q == StPresent) && win_done && row_pending;

`ifdef WRF_PREFETCH_EN
  assign pix_ready = rdy_q && ((state_q == StFill) || !row_pending);
`else
  assign pix_ready = rdy_q && (state_q == StFill);
`endif

  assign win_valid = (state_q == StPresent);
  assign win_count = win_count_q;

  row_collector #(
    .DATA_SIZE (DATA_SIZE),
    .IMG_W     (IMG_W)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_sof     (pix_sof),
    .accept      (accept),
    .hold_row    (hold_row),
    .consume     (consume),
    .row_data    (row_data),
    .row_done    (row_done),
    .row_pending (row_pending)
  );

  // Next state, row/window counters and the stack shift strobe.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    win_count_d = win_count_q;
    shift       = 1'b0;
    case (state_q)
      StFill: begin
        if (row_done) begin
          shift = 1'b1;
          if (row_cnt_q >= RcW'(WIN - 1)) begin
            row_cnt_d   = RcW'(WIN);
            state_d     = StPresent;
            win_count_d = win_count_q + CNT_W'(1);
          end else begin
            row_cnt_d = row_cnt_q + RcW'(1);
          end
        end
      end
      StPresent: begin
        if (win_done) begin
          if (row_done || row_pending) begin
            shift       = 1'b1;
            win_count_d = win_count_q + CNT_W'(1);
          end else begin
            // one fresh row completes the next window
            state_d   = StFill;
            row_cnt_d = RcW'(WIN - 1);
          end
        end
      end
      default: state_d = StFill;
    endcase
    if (sof_acc) begin
      state_d     = StFill;
      row_cnt_d   = '0;
      win_count_d = '0;
    end
  end

  // Control state registers; pix_ready stays low until the first edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFill;
      row_cnt_q   <= '0;
      win_count_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      win_count_q <= win_count_d;
      rdy_q       <= 1'b1;
    end
  end

  // Row stack: oldest row at index 0, newest row enters at WIN-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) begin
        stack_q[i] <= '0;
      end
    end else if (shift) begin
      for (int i = 0; i < WIN - 1; i++) begin
        stack_q[i] <= stack_q[i+1];
      end
      stack_q[WIN-1] <= row_data;
    end
  end

  // Flatten the stack onto the engine bus.
  always_comb begin
    input_array = '0;
    for (int r = 0; r < WIN; r++) begin
      input_array[flat_idx(r, 0, IMG_W)*DATA_SIZE +: RowW] = stack_q[r];
    end
  end

endmodule

// File: tb/tb_window_row_feeder.sv
// Directed bench for window_row_feeder with WIN=3, IMG_W=4, DATA_SIZE=8.
// Works with or without WRF_PREFETCH_EN defined.
module tb_window_row_feeder;

  localparam int unsigned Win   = 3;
  localparam int unsigned Ds    = 8;
  localparam int unsigned ImgW  = 4;
  localparam int unsigned CntW  = 16;

  logic                     clk;
  logic                     rst;
  logic [Ds-1:0]            pix_in;
  logic                     pix_valid;
  logic                     pix_sof;
  logic                     pix_ready;
  logic [Ds*ImgW*Win-1:0]   input_array;
  logic                     win_valid;
  logic                     win_done;
  logic [CntW-1:0]          win_count;

  int n_checks;
  int n_errors;
  int low_cnt;
  logic measuring;

  window_row_feeder #(
    .WIN       (Win),
    .DATA_SIZE (Ds),
    .IMG_W     (ImgW),
    .CNT_W     (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .input_array (input_array),
    .win_valid   (win_valid),
    .win_done    (win_done),
    .win_count   (win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count presented-low cycles while a slide is being measured.
  always @(negedge clk) begin
    if (measuring && !win_valid) low_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [Ds-1:0] elem(input int i);
    return input_array[i*Ds +: Ds];
  endfunction

  // Offer one pixel and return #1 after the edge that accepts it.
  task automatic push(input logic [Ds-1:0] v, input logic sof);
    int n;
    n = 0;
    pix_in    = v;
    pix_sof   = sof;
    pix_valid = 1'b1;
    while (!pix_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!pix_ready) check_eq("push_ready", {63'd0, pix_ready}, 64'd1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic pulse_done();
    win_done = 1'b1;
    @(posedge clk);
    #1;
    win_done = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    low_cnt   = 0;
    measuring = 1'b0;
    rst       = 1'b1;
    pix_in    = '0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    win_done  = 1'b0;

    // Reset state
    #3;
    check_eq("rst_pix_ready", {63'd0, pix_ready}, 64'd0);
    check_eq("rst_win_valid", {63'd0, win_valid}, 64'd0);
    check_eq("rst_array_zero", {63'd0, |input_array}, 64'd0);
    check_eq("rst_win_count", 64'(win_count), 64'd0);
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", {63'd0, pix_ready}, 64'd1);

    // Fill from reset, spurious done in the middle of row 1
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r == 2 && c == 3) check_eq("pre_window_valid", {63'd0, win_valid}, 64'd0);
        push(8'(r * 16 + c), (r == 0 && c == 0));
        if (r == 1 && c == 0) begin
          pulse_done();
          check_eq("spur_win_count", 64'(win_count), 64'd0);
          check_eq("spur_row_cnt", 64'(dut.row_cnt_q), 64'd1);
          check_eq("spur_col_cnt", 64'(dut.u_collector.col_cnt_q), 64'd1);
          check_eq("spur_win_valid", {63'd0, win_valid}, 64'd0);
        end
      end
    end
    check_eq("fill_win_valid", {63'd0, win_valid}, 64'd1);
    check_eq("fill_elem0", 64'(elem(0)), 64'h00);
    check_eq("fill_elem4", 64'(elem(4)), 64'h10);
    check_eq("fill_elem11", 64'(elem(11)), 64'h23);
    check_eq("fill_win_count", 64'(win_count), 64'd1);

`ifdef WRF_PREFETCH_EN
    // Slide with prefetch: row 3 streams while the window is held
    check_eq("pf_ready_present", {63'd0, pix_ready}, 64'd1);
    for (int c = 0; c < 4; c++) push(8'(8'h30 + c), 1'b0);
    check_eq("pf_ready_drop", {63'd0, pix_ready}, 64'd0);
    check_eq("pf_held_valid", {63'd0, win_valid}, 64'd1);
    check_eq("pf_held_elem8", 64'(elem(8)), 64'h20);
    pulse_done();
    check_eq("pf_shift_valid", {63'd0, win_valid}, 64'd1);
`else
    // Slide without prefetch: done, one idle cycle, then one new row
    check_eq("np_ready_present", {63'd0, pix_ready}, 64'd0);
    pulse_done();
    measuring = 1'b1;
    check_eq("np_valid_drop", {63'd0, win_valid}, 64'd0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) push(8'(8'h30 + c), 1'b0);
    measuring = 1'b0;
    check_eq("np_low_cycles", 64'(low_cnt), 64'd5);
    check_eq("np_valid_back", {63'd0, win_valid}, 64'd1);
`endif
    for (int c = 0; c < 4; c++) begin
      check_eq("slide_row0", 64'(elem(c)), 64'(8'h10 + c));
      check_eq("slide_row2", 64'(elem(8 + c)), 64'(8'h30 + c));
    end
    check_eq("slide_row1", 64'(elem(4)), 64'h20);
    check_eq("slide_win_count", 64'(win_count), 64'd2);

    // Async reset while presenting
    rst = 1'b1;
    #3;
    check_eq("arst_win_valid", {63'd0, win_valid}, 64'd0);
    check_eq("arst_array_zero", {63'd0, |input_array}, 64'd0);
    check_eq("arst_pix_ready", {63'd0, pix_ready}, 64'd0);
    check_eq("arst_win_count", 64'(win_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("arst_ready_back", {63'd0, pix_ready}, 64'd1);

    // sof during fill of row 1 restarts the frame
    for (int c = 0; c < 4; c++) push(8'(8'hA0 + c), 1'b0);
    push(8'hB0, 1'b0);
    push(8'hB1, 1'b0);
    push(8'h55, 1'b1);
    check_eq("sof_row_cnt", 64'(dut.row_cnt_q), 64'd0);
    check_eq("sof_col_cnt", 64'(dut.u_collector.col_cnt_q), 64'd1);
    check_eq("sof_win_count", 64'(win_count), 64'd0);
    check_eq("sof_win_valid", {63'd0, win_valid}, 64'd0);
    for (int c = 1; c < 4; c++) push(8'(8'h55 + c), 1'b0);
    for (int r = 1; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r == 2 && c == 3) check_eq("sof_pre_valid", {63'd0, win_valid}, 64'd0);
        push(8'(8'h50 + r * 16 + c), 1'b0);
      end
    end
    check_eq("sof_win_valid2", {63'd0, win_valid}, 64'd1);
    check_eq("sof_elem0", 64'(elem(0)), 64'h55);
    check_eq("sof_elem3", 64'(elem(3)), 64'h58);
    check_eq("sof_elem11", 64'(elem(11)), 64'h73);
    check_eq("sof_win_count2", 64'(win_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
